// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state codes and lamp bit indices shared by the intersection controller.
package traffic_pkg;

  localparam logic [3:0] ST_OFF       = 4'd0;
  localparam logic [3:0] ST_ALLRED_A  = 4'd1;
  localparam logic [3:0] ST_NS_GREEN  = 4'd2;
  localparam logic [3:0] ST_NS_YELLOW = 4'd3;
  localparam logic [3:0] ST_ALLRED_B  = 4'd4;
  localparam logic [3:0] ST_EW_GREEN  = 4'd5;
  localparam logic [3:0] ST_EW_YELLOW = 4'd6;
  localparam logic [3:0] ST_PED_WALK  = 4'd7;
  localparam logic [3:0] ST_FLASH     = 4'd8;

  localparam int RED = 2;
  localparam int YEL = 1;
  localparam int GRN = 0;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - phase cycle counter; done marks the last cycle of a phase of length limit.
module phase_timer #(
  parameter int TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [TIMER_W-1:0] limit,
  output logic [TIMER_W-1:0] count,
  output logic               done
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign count = r_count;
  assign done  = (r_count == (limit - TIMER_W'(1)));

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - NS/EW intersection FSM with all-red clearance,
// latched pedestrian walk phase and flashing-yellow maintenance mode.
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int TIMER_W  = 8,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 10,
  parameter int T_ALLRED = 4,
  parameter int T_WALK   = 20,
  parameter int T_FLASH  = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               flash_mode,
  input  logic               ped_req,
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic               walk,
  output logic               ped_pending,
  output logic [3:0]         state_out,
  output logic [TIMER_W-1:0] timer_out
);

  logic [3:0]         r_state;
  logic               r_ped;
  logic               r_dir;
  logic               r_flash_phase;
  logic [3:0]         w_next;
  logic [TIMER_W-1:0] w_limit;
  logic [TIMER_W-1:0] w_count;
  logic               w_done;
  logic               w_clear;
  logic               w_enter_walk;

  always_comb begin
    case (r_state)
      ST_ALLRED_A, ST_ALLRED_B:  w_limit = TIMER_W'(T_ALLRED);
      ST_NS_GREEN, ST_EW_GREEN:  w_limit = TIMER_W'(T_GREEN);
      ST_NS_YELLOW, ST_EW_YELLOW: w_limit = TIMER_W'(T_YELLOW);
      ST_PED_WALK:               w_limit = TIMER_W'(T_WALK);
      ST_FLASH:                  w_limit = TIMER_W'(T_FLASH);
      default:                   w_limit = TIMER_W'(1);
    endcase
  end

  // enable outranks flash_mode, which outranks the normal cycle
  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = ST_OFF;
    end else if (flash_mode) begin
      w_next = ST_FLASH;
    end else begin
      case (r_state)
        ST_OFF:       w_next = ST_ALLRED_A;
        ST_ALLRED_A:  if (w_done) w_next = r_ped ? ST_PED_WALK : ST_NS_GREEN;
        ST_NS_GREEN:  if (w_done) w_next = ST_NS_YELLOW;
        ST_NS_YELLOW: if (w_done) w_next = ST_ALLRED_B;
        ST_ALLRED_B:  if (w_done) w_next = r_ped ? ST_PED_WALK : ST_EW_GREEN;
        ST_EW_GREEN:  if (w_done) w_next = ST_EW_YELLOW;
        ST_EW_YELLOW: if (w_done) w_next = ST_ALLRED_A;
        ST_PED_WALK:  if (w_done) w_next = r_dir ? ST_EW_GREEN : ST_NS_GREEN;
        ST_FLASH:     w_next = ST_ALLRED_A;
        default:      w_next = ST_OFF;
      endcase
    end
  end

  assign w_enter_walk = (w_next == ST_PED_WALK) && (r_state != ST_PED_WALK);
  assign w_clear      = !enable || (w_next != r_state) || ((r_state == ST_FLASH) && w_done);

  phase_timer #(.TIMER_W(TIMER_W)) u_phase_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .limit (w_limit),
    .count (w_count),
    .done  (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_OFF;
      r_ped         <= 1'b0;
      r_dir         <= 1'b0;
      r_flash_phase <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!enable || (r_state == ST_OFF)) begin
        r_ped <= 1'b0;
      end else begin
        r_ped <= ped_req | (r_ped & ~w_enter_walk);
      end
      // dir remembers which approach gets green after a walk phase
      if (enable && !flash_mode && w_done) begin
        if (r_state == ST_ALLRED_A) r_dir <= 1'b0;
        if (r_state == ST_ALLRED_B) r_dir <= 1'b1;
      end
      if ((w_next == ST_FLASH) && (r_state != ST_FLASH)) begin
        r_flash_phase <= 1'b1;
      end else if ((r_state == ST_FLASH) && w_done) begin
        r_flash_phase <= ~r_flash_phase;
      end
    end
  end

  always_comb begin
    ns_light = 3'b000;
    ew_light = 3'b000;
    case (r_state)
      ST_ALLRED_A, ST_ALLRED_B, ST_PED_WALK: begin
        ns_light[RED] = 1'b1;
        ew_light[RED] = 1'b1;
      end
      ST_NS_GREEN:  begin ns_light[GRN] = 1'b1; ew_light[RED] = 1'b1; end
      ST_NS_YELLOW: begin ns_light[YEL] = 1'b1; ew_light[RED] = 1'b1; end
      ST_EW_GREEN:  begin ew_light[GRN] = 1'b1; ns_light[RED] = 1'b1; end
      ST_EW_YELLOW: begin ew_light[YEL] = 1'b1; ns_light[RED] = 1'b1; end
      ST_FLASH: begin
        ns_light[YEL] = r_flash_phase;
        ew_light[YEL] = r_flash_phase;
      end
      default: ;
    endcase
  end

  assign walk        = (r_state == ST_PED_WALK);
  assign ped_pending = r_ped;
  assign state_out   = r_state;
  assign timer_out   = w_count;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - directed and randomized-input bench with a phase-level reference model.
module tb_traffic_intersection_ctrl;
  import traffic_pkg::*;

  localparam int TW  = 8;
  localparam int TG  = 5;
  localparam int TY  = 2;
  localparam int TA  = 1;
  localparam int TWK = 3;
  localparam int TF  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          flash_mode = 1'b0;
  logic          ped_req = 1'b0;
  logic [2:0]    ns_light;
  logic [2:0]    ew_light;
  logic          walk;
  logic          ped_pending;
  logic [3:0]    state_out;
  logic [TW-1:0] timer_out;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .TIMER_W(TW), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TWK), .T_FLASH(TF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flash_mode(flash_mode), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk), .ped_pending(ped_pending),
    .state_out(state_out), .timer_out(timer_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: current phase plus cycles left in it.
  int m_st = 0;
  int m_left = 1;
  bit m_ped = 0;
  bit m_dir = 0;
  bit m_fp = 0;

  function automatic int dur(input int s);
    case (s)
      1, 4:    return TA;
      2, 5:    return TG;
      3, 6:    return TY;
      7:       return TWK;
      8:       return TF;
      default: return 1;
    endcase
  endfunction

  function automatic int lamps(input int s, input bit fp);
    case (s)
      1, 4, 7: return {3'b100, 3'b100};
      2:       return {3'b001, 3'b100};
      3:       return {3'b010, 3'b100};
      5:       return {3'b100, 3'b001};
      6:       return {3'b100, 3'b010};
      8:       return fp ? {3'b010, 3'b010} : 6'b0;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_left = 1; m_ped = 0; m_dir = 0; m_fp = 0;
    end else if (!enable) begin
      m_st = 0; m_left = 1; m_ped = 0;
    end else begin
      int old;
      int nst;
      old = m_st;
      if (flash_mode) nst = 8;
      else if (old == 8) nst = 1;
      else if (old == 0) nst = 1;
      else if (old > 8) nst = 0;
      else if (m_left > 1) nst = old;
      else begin
        case (old)
          1: begin nst = m_ped ? 7 : 2; m_dir = 0; end
          2: nst = 3;
          3: nst = 4;
          4: begin nst = m_ped ? 7 : 5; m_dir = 1; end
          5: nst = 6;
          6: nst = 1;
          default: nst = m_dir ? 5 : 2;
        endcase
      end
      m_ped = (old == 0) ? 1'b0 : (ped_req | (m_ped & !(nst == 7 && old != 7)));
      if (nst != old) begin
        m_left = dur(nst);
        if (nst == 8) m_fp = 1;
      end else if (nst == 8 && m_left == 1) begin
        m_left = TF;
        m_fp = !m_fp;
      end else begin
        m_left--;
      end
      m_st = nst;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int lp;
      lp = lamps(m_st, m_fp);
      chk("state", int'(state_out), m_st);
      chk("timer", int'(timer_out), dur(m_st) - m_left);
      chk("ns_light", int'(ns_light), (lp >> 3) & 7);
      chk("ew_light", int'(ew_light), lp & 7);
      chk("walk", int'(walk), int'(m_st == 7));
      chk("ped_pending", int'(ped_pending), int'(m_ped));
      if (m_st != 8) chk("no_conflict", int'(ns_light[1:0] != 0 && ew_light[1:0] != 0), 0);
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("rst_state", int'(state_out), 0);
    chk("rst_timer", int'(timer_out), 0);
    chk("rst_lamps", int'({ns_light, ew_light}), 0);
    chk("rst_walk_ped", int'({walk, ped_pending}), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick(1);  chk("c1_allred_a", int'(state_out), 1);
    tick(5);  chk("c6_ns_green", int'(state_out), 2); chk("c6_timer", int'(timer_out), 4);
    tick(1);  chk("c7_ns_yellow", int'(state_out), 3); chk("c7_ns", int'(ns_light), 2);
    chk("c7_ew", int'(ew_light), 4);
    tick(10); chk("c17_period", int'(state_out), 1);
    tick(1);  chk("c18_ns_green", int'(state_out), 2);
    ped_req = 1'b1;
    tick(1);  ped_req = 1'b0; chk("c19_ped_latched", int'(ped_pending), 1);
    tick(7);  chk("c26_walk_state", int'(state_out), 7); chk("c26_walk", int'(walk), 1);
    chk("c26_ped_clear", int'(ped_pending), 0); chk("c26_red", int'({ns_light, ew_light}), 6'o44);
    tick(3);  chk("c29_ew_green", int'(state_out), 5);
    tick(1);  ped_req = 1'b1;
    tick(1);  ped_req = 1'b0; chk("c31_ped", int'(ped_pending), 1);
    tick(5);  chk("c36_allred_a", int'(state_out), 1); ped_req = 1'b1;
    tick(1);  ped_req = 1'b0; chk("c37_walk", int'(state_out), 7);
    chk("c37_ped_kept", int'(ped_pending), 1);
    tick(3);  chk("c40_ns_after_walk", int'(state_out), 2);
    tick(8);  chk("c48_walk_again", int'(state_out), 7); chk("c48_ped_clear", int'(ped_pending), 0);
    tick(3);  chk("c51_ew_after_walk", int'(state_out), 5);
    tick(1);  ped_req = 1'b1;
    tick(1);  ped_req = 1'b0;
    tick(1);  chk("c54_timer", int'(timer_out), 3); enable = 1'b0;
    tick(1);  chk("c55_off", int'(state_out), 0); chk("c55_lamps", int'({ns_light, ew_light}), 0);
    chk("c55_timer", int'(timer_out), 0); chk("c55_ped", int'(ped_pending), 0);
    enable = 1'b1;
    tick(1);  chk("c56_restart", int'(state_out), 1);
    tick(1);  chk("c57_ns_green", int'(state_out), 2);
    tick(1);  flash_mode = 1'b1;
    tick(1);  chk("c59_flash", int'(state_out), 8); chk("c59_ns", int'(ns_light), 2);
    chk("c59_ew", int'(ew_light), 2);
    tick(2);  chk("c61_dark", int'({ns_light, ew_light}), 0);
    tick(2);  chk("c63_ew_on", int'(ew_light), 2);
    tick(1);  flash_mode = 1'b0;
    tick(1);  chk("c65_clearance", int'(state_out), 1);
    tick(1);  chk("c66_ns_green", int'(state_out), 2);
    tick(5);  chk("c71_ns_yellow", int'(state_out), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state_out), 0);
    chk("async_timer", int'(timer_out), 0);
    chk("async_lamps", int'({ns_light, ew_light, walk}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      ped_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) flash_mode = !flash_mode;
      if ($urandom_range(0, 59) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
      tick(1);
    end
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_intersection_ctrl.md
Name: traffic_intersection_ctrl

Overview:
Two-approach intersection controller for north-south (NS) and east-west (EW) traffic. Phase durations are set by parameters and measured in clock cycles. Adds three things a single-lamp semaphore FSM lacks: all-red clearance intervals, a latched pedestrian walk phase, and a flashing-yellow maintenance mode. Sits between the board-level enable/mode inputs and the lamp drivers; state_out and timer_out feed the debug bus.

Parameters:
TIMER_W, 8, width of the phase timer; every T_* must satisfy 1 <= T_* <= 2^TIMER_W - 1
T_GREEN, 30, green phase length in cycles (both approaches)
T_YELLOW, 10, yellow phase length in cycles
T_ALLRED, 4, all-red clearance length in cycles
T_WALK, 20, pedestrian walk phase length in cycles
T_FLASH, 25, flash half-period in cycles (yellow on T_FLASH cycles, off T_FLASH cycles)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  run control; 0 forces OFF
flash_mode  in  1  1 selects flashing-yellow maintenance mode
ped_req  in  1  pedestrian request; a single-cycle pulse is enough
ns_light  out  3  NS lamps {red,yellow,green}
ew_light  out  3  EW lamps {red,yellow,green}
walk  out  1  pedestrian walk lamp
ped_pending  out  1  a pedestrian request is latched and not yet served
state_out  out  4  current state code (debug)
timer_out  out  TIMER_W  current phase timer value (debug)

Behaviour:
- States: OFF, ALLRED_A, NS_GREEN, NS_YELLOW, ALLRED_B, EW_GREEN, EW_YELLOW, PED_WALK, FLASH.
- Reset: state=OFF, timer=0, ped_pending=0, walk=0, ns_light=ew_light=3'b000, internal dir bit=0.
- Moore outputs, decoded combinationally from the registered state (zero latency after a state change).
  - OFF: all lamps 0.
  - ALLRED_x / PED_WALK: both approaches 3'b100; walk=1 only in PED_WALK.
  - NS_GREEN: ns=001, ew=100. NS_YELLOW: ns=010, ew=100.
  - EW_GREEN / EW_YELLOW: mirror of the NS states.
  - FLASH: ns=ew={0,flash_phase,0}.
- Timer:
  - Counts 0..T-1 within a state and clears to 0 on every state change.
  - A state with duration T lasts exactly T cycles; the exit condition is timer==T-1.
  - The timer never wraps inside a timed state.
- Transitions (enable=1, flash_mode=0):
  - OFF -> ALLRED_A next cycle (safe start; never straight to green).
  - ALLRED_A (T_ALLRED) -> PED_WALK if ped_pending, else NS_GREEN; dir:=0.
  - NS_GREEN (T_GREEN) -> NS_YELLOW (T_YELLOW) -> ALLRED_B.
  - ALLRED_B (T_ALLRED) -> PED_WALK if ped_pending, else EW_GREEN; dir:=1.
  - EW_GREEN -> EW_YELLOW -> ALLRED_A.
  - PED_WALK (T_WALK) -> NS_GREEN if dir=0, else EW_GREEN.
- ped_pending:
  - next = ped_req | (ped_pending & ~entering_PED_WALK).
  - A request in the cycle PED_WALK is entered stays latched and is served at the next all-red.
  - Requests while in OFF are ignored (pending held at 0).
- Priority, evaluated each cycle:
  - enable=0: next state OFF, timer cleared, ped_pending cleared; this applies from any state, mid-phase included.
  - Otherwise flash_mode=1: next state FLASH from any state.
  - Otherwise the normal table above.
- FLASH:
  - On entry, flash_phase=1 and timer=0.
  - When timer==T_FLASH-1: toggle flash_phase and clear the timer.
  - flash_mode falling -> ALLRED_A (full clearance before any green).
  - ped_pending keeps latching in FLASH.
- Unused state codes decode as OFF outputs and go to OFF next cycle.

Decomposition:
- Package traffic_pkg holds:
  - the 4-bit state codes: OFF=0, ALLRED_A=1, NS_GREEN=2, NS_YELLOW=3, ALLRED_B=4, EW_GREEN=5, EW_YELLOW=6, PED_WALK=7, FLASH=8;
  - the lamp bit indices: RED=2, YEL=1, GRN=0.
- Sub-module phase_timer (param TIMER_W):
  - inputs: clk, rst_n, clear, limit[TIMER_W-1:0];
  - outputs: count, done, where done = (count==limit-1).
  - The FSM drives clear on every state change and on enable=0.

Test Plan:
All scenarios use T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_FLASH=2.
1. Reset, then enable=1 held: OFF (1 cycle), then ALLRED_A 1, NS_GREEN 5, NS_YELLOW 2, ALLRED_B 1, EW_GREEN 5, EW_YELLOW 2, back to ALLRED_A. Period is 16 cycles. No cycle ever has green or yellow on both approaches.
2. Pulse ped_req during NS_GREEN: ped_pending=1 next cycle. After ALLRED_B, PED_WALK with walk=1 for 3 cycles, both approaches red, ped_pending=0. Then EW_GREEN.
3. ped_req pulsed on the exact cycle PED_WALK is entered: ped_pending stays 1, and the next all-red enters PED_WALK again.
4. Drop enable at timer=3 of EW_GREEN: OFF next cycle, lamps 000, timer=0, ped_pending=0. Re-enable: restart at ALLRED_A.
5. Assert flash_mode in NS_GREEN: FLASH next cycle. ns=ew=010 for 2 cycles, then 000 for 2 cycles, repeating. Deassert: ALLRED_A for 1 cycle, then NS_GREEN.
6. Assert rst_n low mid-NS_YELLOW, asynchronously between clock edges: outputs go immediately to all 0, state_out=0, timer_out=0.
